// File: rtl/lmsm_sequencer.sv
// IITB-RISC load/store-multiple sequencer: walks a register mask low-to-high, one memory and one
// register-file access per set bit. Optional macro LMSM_TIMEOUT_EN aborts a transfer stuck on mem_ready.
module lmsm_sequencer #(
  parameter int NUM_REGS       = 8,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start,
  input  logic                is_load,
  input  logic [NUM_REGS-1:0] reg_mask,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [3:0]          xfer_count,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic [5:0]          rf_read_addr,
  input  logic [31:0]         rf_read_data,
  output logic [2:0]          rf_write_addr,
  output logic                rf_wr_en,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [1:0]          state_dbg
);

  // Handshake: a strobe (mem_rd/mem_wr) with address and data is held until a cycle in which
  // mem_ready is high; that cycle completes the access and the next register is selected.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DONE = 2'd2} state_t;

  state_t              state;
  logic [NUM_REGS-1:0] mask_q;
  logic [NUM_REGS-1:0] mask_clr;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          cnt_q;
  logic                busy_q, done_q, rd_q, wr_q;
  logic [2:0]          p;
  logic                unused_rf_hi;

  // Lowest set bit of the remaining mask selects the current register.
  always_comb begin
    p = 3'd0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (mask_q[i]) p = i[2:0];
    end
  end

  assign mask_clr = mask_q & (mask_q - NUM_REGS'(1));

`ifdef LMSM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WAIT_W-1:0] wait_q;
  logic              err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= S_IDLE;
      mask_q <= '0;
      addr_q <= '0;
      cnt_q  <= 4'd0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
`ifdef LMSM_TIMEOUT_EN
      wait_q <= '0;
      err_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mask_q <= reg_mask;
            addr_q <= base_addr;
            cnt_q  <= 4'd0;
`ifdef LMSM_TIMEOUT_EN
            wait_q <= '0;
            err_q  <= 1'b0;
`endif
            if (reg_mask != '0) begin
              state  <= S_ISSUE;
              busy_q <= 1'b1;
              rd_q   <= is_load;
              wr_q   <= !is_load;
            end else begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (mem_ready) begin
            mask_q <= mask_clr;
            addr_q <= addr_q + ADDR_W'(1);
            cnt_q  <= cnt_q + 4'd1;
`ifdef LMSM_TIMEOUT_EN
            wait_q <= '0;
`endif
            if (mask_clr == '0) begin
              state  <= S_DONE;
              busy_q <= 1'b0;
              rd_q   <= 1'b0;
              wr_q   <= 1'b0;
              done_q <= 1'b1;
            end
          end
`ifdef LMSM_TIMEOUT_EN
          else if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            wait_q <= wait_q + WAIT_W'(1);
          end
`endif
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign xfer_count    = cnt_q;
  assign mem_addr      = addr_q;
  assign mem_rd        = rd_q;
  assign mem_wr        = wr_q;
  assign mem_wdata     = rf_read_data[DATA_W-1:0];
  assign rf_read_addr  = {p, p};
  assign rf_write_addr = p;
  assign rf_wr_en      = rd_q & mem_ready;
  assign rf_wdata      = mem_rdata;
  assign state_dbg     = state;
  assign unused_rf_hi  = ^rf_read_data[31:DATA_W];

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: directed and randomized LM/SM operations checked
// against a transfer list derived from the mask, plus reset and (optional) timeout scenarios.
module tb_lmsm_sequencer;

  localparam int W = 19;  // {addr[15:0], reg[2:0]}

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic [7:0]  reg_mask = 8'h00;
  logic [15:0] base_addr = 16'h0000;
  logic        busy, done, err;
  logic [3:0]  xfer_count;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, rf_wdata;
  logic        mem_rd, mem_wr, rf_wr_en;
  logic        mem_ready = 1'b0;
  logic [5:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [2:0]  rf_write_addr;
  logic [1:0]  state_dbg;

  logic [15:0] tb_mem [65536];
  logic [15:0] rf_m [8];
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  lmsm_sequencer dut (
    .clk(clk), .resetn(resetn), .start(start), .is_load(is_load), .reg_mask(reg_mask),
    .base_addr(base_addr), .busy(busy), .done(done), .err(err), .xfer_count(xfer_count),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .rf_read_addr(rf_read_addr),
    .rf_read_data(rf_read_data), .rf_write_addr(rf_write_addr), .rf_wr_en(rf_wr_en),
    .rf_wdata(rf_wdata), .state_dbg(state_dbg)
  );

  // clock / environment: memory and register file respond to the DUT strobes
  always #5 clk = ~clk;
  assign mem_rdata    = tb_mem[mem_addr];
  assign rf_read_data = {16'hDEAD, rf_m[rf_read_addr[2:0]]};
  always @(posedge clk) begin
    if (rf_wr_en) rf_m[rf_write_addr] <= rf_wdata;
    if (mem_wr && mem_ready) tb_mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation; stall_len cycles of mem_ready=0 precede transfer stall_idx,
  // other cycles stall randomly with probability stall_pct (never 10 in a row).
  task automatic run_op(input logic ld, input logic [7:0] m, input logic [15:0] b,
                        input int stall_idx, input int stall_len, input int stall_pct);
    int n, stalls, cyc, held, xi, consec;
    logic rdy, finished;
    logic [15:0] a;
    logic [2:0] pe;
    int regs_l[$];
    logic [15:0] addr_l[$];
    logic [15:0] val_l[$];
    exp_q.delete();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        a = b + 16'(n);
        exp_q.push_back({a, 3'(i)});
        regs_l.push_back(i);
        addr_l.push_back(a);
        val_l.push_back(ld ? tb_mem[a] : rf_m[i]);
        n++;
      end
    end
    @(posedge clk); #1;
    start = 1'b1; is_load = ld; reg_mask = m; base_addr = b;
    mem_ready = 1'($urandom_range(1));
    @(posedge clk); #1;
    cyc = 1; stalls = 0; xi = 0; held = 0; consec = 0; finished = 1'b0;
    while (!finished && cyc < 300) begin
      start = 1'($urandom_range(1));
      reg_mask = 8'($urandom);
      base_addr = 16'($urandom);
      is_load = 1'($urandom_range(1));
      if (xi == stall_idx && held < stall_len) rdy = 1'b0;
      else if (consec >= 9) rdy = 1'b1;
      else rdy = ($urandom_range(99) >= stall_pct);
      mem_ready = rdy;
      @(negedge clk);
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("extra_xfer", 32'(busy), 32'd0);
          finished = 1'b1;
        end else begin
          a = exp_q[0][18:3];
          pe = exp_q[0][2:0];
          chk("mem_addr", 32'(mem_addr), 32'(a));
          chk("rf_write_addr", 32'(rf_write_addr), 32'(pe));
          chk("rf_read_addr", 32'(rf_read_addr), 32'({pe, pe}));
          chk("mem_rd", 32'(mem_rd), 32'(ld));
          chk("mem_wr", 32'(mem_wr), 32'(!ld));
          chk("rf_wr_en", 32'(rf_wr_en), 32'(ld && rdy));
          chk("done_in_issue", 32'(done), 32'd0);
          if (ld && rdy) chk("rf_wdata", 32'(rf_wdata), 32'(tb_mem[a]));
          if (!ld) chk("mem_wdata", 32'(mem_wdata), 32'(rf_m[pe]));
          if (rdy) begin
            void'(exp_q.pop_front());
            xi++; held = 0; consec = 0;
          end else begin
            stalls++; held++; consec++;
          end
        end
      end else if (done) begin
        chk("done_latency", 32'(cyc), 32'(n + stalls + 1));
        chk("xfer_count", 32'(xfer_count), 32'(n));
        chk("err", 32'(err), 32'd0);
        chk("left_over", 32'(exp_q.size()), 32'd0);
        chk("strobes_in_done", 32'({mem_rd, mem_wr, rf_wr_en}), 32'd0);
        finished = 1'b1;
      end else begin
        chk("dropped_op", 32'({busy, done}), 32'd1);
        finished = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (!finished) chk("op_cycle_budget", 32'd0, 32'd1);
    start = 1'b0;
    mem_ready = 1'b0;
    chk("done_one_cycle", 32'({busy, done}), 32'd0);
    for (int k = 0; k < regs_l.size(); k++) begin
      if (ld) chk("rf_loaded", 32'(rf_m[regs_l[k]]), 32'(val_l[k]));
      else    chk("mem_stored", 32'(tb_mem[addr_l[k]]), 32'(val_l[k]));
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) tb_mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) rf_m[i] = 16'($urandom);

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_strobes", 32'({mem_rd, mem_wr, rf_wr_en}), 32'd0);
    chk("rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // directed: LM three registers, SM all with wrap, empty mask, LM with a held access
    run_op(1'b1, 8'b1000_0101, 16'h0040, -1, 0, 0);
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h1000 + 16'(i);
    run_op(1'b0, 8'hFF, 16'hFFFE, -1, 0, 0);
    run_op(1'b1, 8'h00, 16'h1234, -1, 0, 0);
    run_op(1'b1, 8'b0000_0110, 16'h0200, 1, 3, 0);
`ifndef LMSM_TIMEOUT_EN
    run_op(1'b1, 8'h10, 16'h0300, 0, 20, 0);
`endif

    // reset during the second SM transfer
    @(posedge clk); #1;
    start = 1'b1; is_load = 1'b0; reg_mask = 8'hFF; base_addr = 16'h0500; mem_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    mem_ready = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_strobes", 32'({mem_rd, mem_wr, rf_wr_en}), 32'd0);
    chk("mid_rst_xfer_count", 32'(xfer_count), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    for (int k = 0; k < 4; k++) begin
      mem_ready = 1'($urandom_range(1));
      @(negedge clk);
      chk("mid_rst_no_done", 32'({busy, done, mem_rd, mem_wr, rf_wr_en}), 32'd0);
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    run_op(1'b1, 8'h01, 16'($urandom), -1, 0, 0);

`ifdef LMSM_TIMEOUT_EN
    begin
      logic [15:0] b, pre1;
      int stalls;
      logic got_done;
      b = 16'($urandom);
      pre1 = rf_m[1];
      @(posedge clk); #1;
      start = 1'b1; is_load = 1'b1; reg_mask = 8'h03; base_addr = b;
      @(posedge clk); #1;
      start = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      chk("to_first_wr", 32'({rf_wr_en, rf_write_addr}), 32'({1'b1, 3'd0}));
      @(posedge clk); #1;
      mem_ready = 1'b0;
      stalls = 0; got_done = 1'b0;
      for (int k = 0; k < 40 && !got_done; k++) begin
        @(negedge clk);
        if (done) got_done = 1'b1;
        else begin
          chk("to_stall_busy", 32'({busy, rf_wr_en}), 32'({1'b1, 1'b0}));
          stalls++;
        end
        @(posedge clk); #1;
      end
      chk("to_got_done", 32'(got_done), 32'd1);
      chk("to_stalls", 32'(stalls), 32'd15);
      chk("to_err", 32'(err), 32'd1);
      chk("to_xfer_count", 32'(xfer_count), 32'd1);
      chk("to_r1_kept", 32'(rf_m[1]), 32'(pre1));
      chk("to_r0_loaded", 32'(rf_m[0]), 32'(tb_mem[b]));
    end
`endif

    // randomized operations
    for (int t = 0; t < 12; t++) begin
      run_op(1'($urandom_range(1)), 8'($urandom), 16'($urandom), -1, 0, 30);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
